// File: rtl/matvec_pkg.sv
// Shared widths, FSM encoding and byte-slice helper for the
// matrix-vector job scheduler.
package matvec_pkg;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 16;
    localparam int VEC_W  = ELEM_W * N_ELEM;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [ELEM_W-1:0] elem(
        input logic [VEC_W-1:0] v,
        input logic [3:0]       i
    );
        return v[ELEM_W*i +: ELEM_W];
    endfunction

endpackage

// File: rtl/matvec_dot_row.sv
// One matrix row times x plus one b byte, truncated to 8 bits.
module matvec_dot_row
    import matvec_pkg::*;
(
    input  logic [VEC_W-1:0]  q,
    input  logic [VEC_W-1:0]  x,
    input  logic [ELEM_W-1:0] b,
    output logic [ELEM_W-1:0] y
);

    always_comb begin
        logic [2*ELEM_W-1:0] prod;
        logic [ELEM_W-1:0]   acc;
        prod = '0;
        acc  = b;
        for (int j = 0; j < N_ELEM; j++) begin
            prod = elem(q, 4'(j)) * elem(x, 4'(j));
            acc  = acc + prod[ELEM_W-1:0];
        end
        y = acc;
    end

endmodule

// File: rtl/matvec_job_sched.sv
// Round-robin job scheduler sharing one row ROM and dot-product
// datapath between NREQ requesters.
module matvec_job_sched
    import matvec_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ROM_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*VEC_W-1:0] vector_x,
    input  logic [NREQ*VEC_W-1:0] vector_b,
    output logic [NREQ-1:0]       gnt,
    output logic [3:0]            A,
    input  logic [VEC_W-1:0]      Q,
    output logic [VEC_W-1:0]      vector_y,
    output logic [NREQ-1:0]       done,
    output logic                  busy
);

    state_e             state;
    logic [3:0]         cnt;
    logic [1:0]         dcnt;
    logic [1:0]         ptr;
    logic [1:0]         owner;
    logic [1:0]         pick;
    logic [VEC_W-1:0]   x_r;
    logic [VEC_W-1:0]   b_r;
    logic [VEC_W-1:0]   y_work;
    logic [VEC_W-1:0]   y_next;
    logic [ELEM_W-1:0]  row_y;
    logic [ROM_LAT-1:0] pv;
    logic [3:0]         pidx [ROM_LAT];
    logic               cap_v;
    logic [3:0]         cap_i;

    assign busy  = (state != IDLE);
    assign cap_v = pv[ROM_LAT-1];
    assign cap_i = pidx[ROM_LAT-1];

    // First requester at or after the round-robin pointer.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = 2'(idx);
            end
        end
    end

    matvec_dot_row u_dot (
        .q (Q),
        .x (x_r),
        .b (elem(b_r, cap_i)),
        .y (row_y)
    );

    always_comb begin
        y_next = y_work;
        if (cap_v)
            y_next[ELEM_W*cap_i +: ELEM_W] = row_y;
    end

    // Row index travels alongside the ROM latency.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pv <= '0;
            for (int i = 0; i < ROM_LAT; i++)
                pidx[i] <= '0;
        end else begin
            pv[0]   <= (state == RUN);
            pidx[0] <= cnt;
            for (int i = 1; i < ROM_LAT; i++) begin
                pv[i]   <= pv[i-1];
                pidx[i] <= pidx[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            gnt      <= '0;
            done     <= '0;
            A        <= '0;
            vector_y <= '0;
            x_r      <= '0;
            b_r      <= '0;
            y_work   <= '0;
            cnt      <= '0;
            dcnt     <= '0;
            ptr      <= '0;
            owner    <= '0;
        end else begin
            done   <= '0;
            y_work <= y_next;
            unique case (state)
                IDLE: begin
                    A <= '0;
                    if (|req) begin
                        gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        owner <= pick;
                        x_r   <= vector_x[pick*VEC_W +: VEC_W];
                        b_r   <= vector_b[pick*VEC_W +: VEC_W];
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        A     <= 4'd15;
                        dcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        A <= cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (dcnt == 2'(ROM_LAT - 1)) begin
                        vector_y <= y_next;
                        done     <= gnt;
                        A        <= '0;
                        state    <= DONE;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    ptr   <= (int'(owner) == NREQ - 1) ? 2'd0 : owner + 2'd1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
